// File: rtl/regfile_sequencer.sv
// regfile_sequencer: initiator for the register-file strobe protocol.
// Takes one request (two source registers, one destination), strobes the
// operands out of the register file, offers them to the ALU, and optionally
// writes the ALU result back with a single z_enb pulse.
module regfile_sequencer #(
  parameter int w     = 8,
  parameter int sel_w = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [sel_w-1:0] req_x,
  input  logic [sel_w-1:0] req_y,
  input  logic [sel_w-1:0] req_z,
  input  logic             req_wb,
  output logic [sel_w-1:0] rf_x_sel,
  output logic [sel_w-1:0] rf_y_sel,
  output logic [sel_w-1:0] rf_z_sel,
  output logic             rf_x_enb,
  output logic             rf_y_enb,
  output logic             rf_z_enb,
  input  logic [w-1:0]     rf_x_out,
  input  logic [w-1:0]     rf_y_out,
  output logic [w-1:0]     rf_z_in,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [w-1:0]     op_a,
  output logic [w-1:0]     op_b,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [w-1:0]     res_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_STROBE,
    OP_OFFER,
    RES_WAIT,
    WB_SETUP,
    WB_STROBE
  } state_e;

  state_e           state_q, state_d;
  logic [sel_w-1:0] x_sel_q, x_sel_d;
  logic [sel_w-1:0] y_sel_q, y_sel_d;
  logic [sel_w-1:0] z_sel_q, z_sel_d;
  logic [sel_w-1:0] z_dst_q, z_dst_d;   // destination held until the write-back is committed
  logic             wb_q, wb_d;
  logic             x_enb_q, x_enb_d;
  logic             y_enb_q, y_enb_d;
  logic             z_enb_q, z_enb_d;
  logic [w-1:0]     z_in_q, z_in_d;
  logic             op_valid_q, op_valid_d;
  logic [w-1:0]     op_a_q, op_a_d;
  logic [w-1:0]     op_b_q, op_b_d;
  logic             res_ready_q, res_ready_d;

  // State and registered outputs; reset clears every output immediately.
  // NOTE: reset is asynchronous so an abort drops all strobes at once, without
  // waiting for a clock edge; all state uses non-blocking assignment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_sel_q     <= '0;
      y_sel_q     <= '0;
      z_sel_q     <= '0;
      z_dst_q     <= '0;
      wb_q        <= 1'b0;
      x_enb_q     <= 1'b0;
      y_enb_q     <= 1'b0;
      z_enb_q     <= 1'b0;
      z_in_q      <= '0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_sel_q     <= x_sel_d;
      y_sel_q     <= y_sel_d;
      z_sel_q     <= z_sel_d;
      z_dst_q     <= z_dst_d;
      wb_q        <= wb_d;
      x_enb_q     <= x_enb_d;
      y_enb_q     <= y_enb_d;
      z_enb_q     <= z_enb_d;
      z_in_q      <= z_in_d;
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_ready_q <= res_ready_d;
    end
  end

  // Next-state and next-output logic for the strobe sequence.
  // NOTE: every _d defaults to its _q first, so no path can infer a latch and
  // anything not touched in a state simply holds.
  always_comb begin
    state_d     = state_q;
    x_sel_d     = x_sel_q;
    y_sel_d     = y_sel_q;
    z_sel_d     = z_sel_q;
    z_dst_d     = z_dst_q;
    wb_d        = wb_q;
    x_enb_d     = x_enb_q;
    y_enb_d     = y_enb_q;
    z_enb_d     = z_enb_q;
    z_in_d      = z_in_q;
    op_valid_d  = op_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_ready_d = res_ready_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Selects go out now so they settle a full cycle before the strobe.
          x_sel_d = req_x;
          y_sel_d = req_y;
          z_dst_d = req_z;
          wb_d    = req_wb;
          state_d = RD_SETUP;
        end
      end
      RD_SETUP: begin
        x_enb_d = 1'b1;
        y_enb_d = 1'b1;
        state_d = RD_STROBE;
      end
      RD_STROBE: begin
        op_a_d     = rf_x_out;
        op_b_d     = rf_y_out;
        x_enb_d    = 1'b0;
        y_enb_d    = 1'b0;
        op_valid_d = 1'b1;
        state_d    = OP_OFFER;
      end
      OP_OFFER: begin
        if (op_ready) begin
          op_valid_d  = 1'b0;
          res_ready_d = 1'b1;
          state_d     = RES_WAIT;
        end
      end
      RES_WAIT: begin
        if (res_valid && res_ready_q) begin
          res_ready_d = 1'b0;
          if (wb_q) begin
            z_in_d  = res_data;
            z_sel_d = z_dst_q;
            state_d = WB_SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WB_SETUP: begin
        z_enb_d = 1'b1;
        state_d = WB_STROBE;
      end
      WB_STROBE: begin
        // z_sel/z_in stay put so the regfile can sample them on the falling edge.
        z_enb_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rf_x_sel  = x_sel_q;
  assign rf_y_sel  = y_sel_q;
  assign rf_z_sel  = z_sel_q;
  assign rf_x_enb  = x_enb_q;
  assign rf_y_enb  = y_enb_q;
  assign rf_z_enb  = z_enb_q;
  assign rf_z_in   = z_in_q;
  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign res_ready = res_ready_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Testbench for regfile_sequencer: behavioural register file, directed ALU
// handshakes with hand-computed expected values.
module tb_regfile_sequencer;
  localparam int W  = 8;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [SW-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic          req_wb = 1'b0;
  logic [SW-1:0] rf_x_sel, rf_y_sel, rf_z_sel;
  logic          rf_x_enb, rf_y_enb, rf_z_enb;
  logic [W-1:0]  rf_x_out, rf_y_out, rf_z_in;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [W-1:0]  op_a, op_b;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [W-1:0]  res_data = '0;
  logic          busy;

  regfile_sequencer #(.w(W), .sel_w(SW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_wb(req_wb),
    .rf_x_sel(rf_x_sel), .rf_y_sel(rf_y_sel), .rf_z_sel(rf_z_sel),
    .rf_x_enb(rf_x_enb), .rf_y_enb(rf_y_enb), .rf_z_enb(rf_z_enb),
    .rf_x_out(rf_x_out), .rf_y_out(rf_y_out), .rf_z_in(rf_z_in),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // All registered outputs packed together for the reset checks.
  logic [40:0] reg_outs;
  assign reg_outs = {rf_x_sel, rf_y_sel, rf_z_sel, rf_x_enb, rf_y_enb, rf_z_enb,
                     rf_z_in, op_valid, op_a, op_b, res_ready};

  // Register file model: reads visible while strobed, write on falling edge.
  logic [W-1:0] rf_mem [16];
  assign rf_x_out = rf_x_enb ? rf_mem[rf_x_sel] : '0;
  assign rf_y_out = rf_y_enb ? rf_mem[rf_y_sel] : '0;

  int           cyc = 0;
  int           x_pulses = 0, y_pulses = 0, z_pulses = 0, back2back = 0;
  logic         x_prev = 1'b0, y_prev = 1'b0, z_prev = 1'b0;
  logic [SW-1:0] last_z_sel = '0;
  logic [W-1:0]  last_z_in = '0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (rf_z_enb) begin
      rf_mem[rf_z_sel] = rf_z_in;
      last_z_sel = rf_z_sel;
      last_z_in  = rf_z_in;
      z_pulses++;
    end
    if (rf_x_enb) x_pulses++;
    if (rf_y_enb) y_pulses++;
    if ((rf_x_enb && x_prev) || (rf_y_enb && y_prev) || (rf_z_enb && z_prev)) back2back++;
    x_prev = rf_x_enb;
    y_prev = rf_y_enb;
    z_prev = rf_z_enb;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step to just after the next falling edge: sample and drive from here.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_ready(input string t);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check({t, " ready"}, req_ready, 1'b1);
  endtask

  // Full transaction: os = op_ready stall cycles, rs = res_valid late cycles.
  task automatic do_op(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic [SW-1:0] z,
                       input logic wb, input int os, input int rs,
                       input logic [W-1:0] ea, input logic [W-1:0] eb, input string t);
    int xa, ya, za, ca, ci, n;
    logic [W-1:0] res;
    res = ea + eb;
    wait_ready(t);
    xa = x_pulses; ya = y_pulses; za = z_pulses;
    req_valid = 1'b1; req_x = x; req_y = y; req_z = z; req_wb = wb;
    tick();
    // Scramble request fields: the DUT must have latched them.
    req_valid = 1'b0; req_x = ~x; req_y = ~y; req_z = ~z; req_wb = ~wb;
    ca = cyc;
    check({t, " busy"}, {busy, req_ready, op_valid}, 3'b100);
    tick();
    check({t, " rd strobe"}, {rf_x_enb, rf_y_enb, op_valid, rf_x_sel, rf_y_sel}, {3'b110, x, y});
    tick();
    check({t, " operands"}, {op_valid, rf_x_enb, rf_y_enb, op_a, op_b}, {3'b100, ea, eb});
    // Stray results during the offer must be ignored.
    res_valid = (os > 0); res_data = 8'hEE;
    op_ready  = (os == 0);
    for (int i = 0; i < os; i++) begin
      tick();
      check({t, " offer hold"}, {op_valid, res_ready, op_a, op_b}, {2'b10, ea, eb});
      if (i == os - 1) begin
        op_ready  = 1'b1;
        res_valid = 1'b0;
      end
    end
    tick();
    op_ready = 1'b0;
    check({t, " op handshake"}, {op_valid, res_ready}, 2'b01);
    res_valid = (rs == 0); res_data = res;
    for (int i = 0; i < rs; i++) begin
      tick();
      check({t, " res wait"}, {res_ready, busy}, 2'b11);
      if (i == rs - 1) res_valid = 1'b1;
    end
    tick();
    res_valid = 1'b0; res_data = '0;
    check({t, " res handshake"}, res_ready, 1'b0);
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    ci = cyc;
    check({t, " cycles"}, ci - ca, (wb ? 6 : 4) + os + rs);
    check({t, " read pulses"}, {x_pulses - xa, y_pulses - ya}, {32'd1, 32'd1});
    check({t, " z pulses"}, z_pulses - za, wb ? 1 : 0);
    if (wb) check({t, " z write"}, {last_z_sel, last_z_in, rf_z_sel, rf_z_in}, {z, res, z, res});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;

    // 1: reset held, then released
    tick(); tick();
    check("in reset", {reg_outs, req_ready, busy}, {41'd0, 2'b10});
    reset = 1'b1;
    tick(); tick();
    check("after reset", {reg_outs, req_ready, busy}, {41'd0, 2'b10});

    // 2: write-back transaction
    rf_mem[3] = 8'h12; rf_mem[5] = 8'h34;
    do_op(4'd3, 4'd5, 4'd7, 1'b1, 0, 0, 8'h12, 8'h34, "t2");
    check("t2 r7", rf_mem[7], 8'h46);

    // 3: same request, result discarded
    rf_mem[7] = 8'hAA;
    do_op(4'd3, 4'd5, 4'd7, 1'b0, 0, 0, 8'h12, 8'h34, "t3");
    check("t3 r7 untouched", rf_mem[7], 8'hAA);
    check("t3 z_sel held", {rf_z_sel, rf_z_in}, {4'd7, 8'h46});

    // 4: ALU stalls on both handshakes
    do_op(4'd3, 4'd5, 4'd9, 1'b1, 5, 3, 8'h12, 8'h34, "t4");
    check("t4 r9", rf_mem[9], 8'h46);

    // 5: back-to-back read-modify-write on one register
    rf_mem[2] = 8'h01;
    do_op(4'd2, 4'd2, 4'd2, 1'b1, 0, 0, 8'h01, 8'h01, "t5a");
    do_op(4'd2, 4'd2, 4'd2, 1'b1, 0, 0, 8'h02, 8'h02, "t5b");
    check("t5 r2", rf_mem[2], 8'h04);

    // 6: reset during the operand offer
    begin
      int za;
      rf_mem[4] = 8'h77;
      wait_ready("t6");
      za = z_pulses;
      req_valid = 1'b1; req_x = 4'd3; req_y = 4'd5; req_z = 4'd4; req_wb = 1'b1;
      tick();
      req_valid = 1'b0;
      tick(); tick();
      check("t6 offering", op_valid, 1'b1);
      op_ready = 1'b1;
      reset = 1'b0;
      #1;
      check("t6 abort", {reg_outs, req_ready, busy}, {41'd0, 2'b10});
      tick(); tick();
      op_ready = 1'b0;
      res_valid = 1'b1; res_data = 8'h55;
      tick();
      res_valid = 1'b0;
      reset = 1'b1;
      tick(); tick(); tick();
      check("t6 idle", {reg_outs, req_ready, busy}, {41'd0, 2'b10});
      check("t6 no write", {z_pulses - za, 24'd0, rf_mem[4]}, {32'd0, 24'd0, 8'h77});
    end

    check("strobe spacing", back2back, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
